inst_cache_2way: RTL and testbench
==================================

INST_CACHE_2WAY -- requirements
Module: inst_cache_2way

Interface
REQ-001 SHALL have parameter INDEX_WIDTH, default 7: sets = 2^INDEX_WIDTH.
REQ-002 SHALL have parameter OFFSET_WIDTH, default 4 (minimum 2): line bytes; WORDS = 2^(OFFSET_WIDTH-2); TAG_WIDTH = 32-INDEX_WIDTH-OFFSET_WIDTH.
REQ-003 SHALL have one clock; reset is asynchronous and active-high.
REQ-004 clk  in  1  clock, all state on rising edge.
REQ-005 rst  in  1  asynchronous active-high reset.
REQ-006 inv_all  in  1  invalidate every line (single-cycle pulse).
REQ-007 cpu_inst_req / cpu_inst_wr  in  1/1  core request / write flag (wr ignored).
REQ-008 cpu_inst_size / cpu_inst_addr / cpu_inst_wdata  in  2/32/32  size (ignored) / byte address / write data (ignored).
REQ-009 cpu_inst_rdata / cpu_inst_addr_ok / cpu_inst_data_ok  out  32/1/1  instruction word / address accepted / data valid.
REQ-010 cache_inst_req / cache_inst_wr / cache_inst_size  out  1/1/2  bus request / constant 0 / constant 2'b10.
REQ-011 cache_inst_addr / cache_inst_wdata  out  32/32  word address / constant 0.
REQ-012 cache_inst_rdata / cache_inst_addr_ok / cache_inst_data_ok  in  32/1/1  bus sram-like return channel.

Function
REQ-013 Storage: 2 ways x sets; per line valid, tag, WORDS x 32-bit data; per set one LRU bit (value = way to replace next).
REQ-014 Address split: offset = addr[OFFSET_WIDTH-1:0], word select = addr[OFFSET_WIDTH-1:2], index next INDEX_WIDTH bits, tag remaining upper bits.
REQ-015 Uncached: addr[31:29]==3'b101 SHALL bypass lookup and never allocate.
REQ-016 FSM states IDLE, REFILL, UNCACHED, RESP; reset to IDLE.
REQ-017 IDLE hit (cached, req, valid and tag match in either way): cpu_inst_addr_ok=cpu_inst_data_ok=1 same cycle, rdata = hit way word combinationally; LRU of set <= other way.
REQ-018 IDLE miss: capture tag/index/word/uncached flag, addr_ok stays 0, go REFILL (cached) or UNCACHED.
REQ-019 Victim: way0 if invalid, else way1 if invalid, else LRU way; chosen at miss entry.
REQ-020 REFILL: WORDS sequential reads, word counter 0..WORDS-1, cache_inst_addr = {tag,index,counter,2'b00}; one outstanding request.
REQ-021 cache_inst_req = (REFILL|UNCACHED) & ~addr_rcv; addr_rcv set on req&addr_ok, cleared on data_ok; at most one addr_ok per data_ok.
REQ-022 Each REFILL data_ok stores rdata in line buffer[counter], counter+1; on last word write valid=1, tag, buffer to victim, LRU <= other way, go RESP.
REQ-023 UNCACHED: single read of captured address with [1:0]=00; data_ok latches word, go RESP.
REQ-024 RESP (one cycle): cpu_inst_addr_ok=cpu_inst_data_ok=1, rdata = saved word; go IDLE; no new lookup accepted that cycle.
REQ-025 Core holds req and addr stable until addr_ok; block SHALL use only captured values outside IDLE.
REQ-026 inv_all clears all valid and LRU bits next edge; ignored unless IDLE; in IDLE it SHALL suppress the hit that cycle (addr_ok=0).
REQ-027 Bus data_ok arriving with addr_rcv=0 SHALL be ignored.
REQ-028 In IDLE with cpu_inst_req=0: addr_ok=data_ok=0, no state change.

Reset
REQ-029 rst SHALL asynchronously force state=IDLE, counter=0, addr_rcv=0, all valid=0, all LRU=0; data/tag arrays not reset.
REQ-030 During rst: cache_inst_req=0, cpu_inst_addr_ok=0, cpu_inst_data_ok=0; outstanding bus transfer abandoned, its late data_ok ignored per REQ-027.

Verification
REQ-031 Cold read 0x00001004, bus returns 0x11,0x22,0x33,0x44 for 0x1000..0x100C -> 4 bus reqs in order, RESP rdata=0x22; reread 0x0000100C hits same cycle rdata=0x44.
REQ-032 Fill set 0 with tags A,B, hit A, miss tag C -> C replaces B (way1); then tag B misses and replaces A.
REQ-033 Read 0xBFC00000 twice -> two single-word bus reads, never hits, cache contents unchanged.
REQ-034 inv_all after fill of 0x1000 line -> next read 0x1000 misses and refills 4 words.
REQ-035 Bus addr_ok delayed 3 cycles and data_ok 5 cycles per word -> cache_inst_req stays 1 until addr_ok, never two unacknowledged addresses, result correct.
REQ-036 rst asserted mid-REFILL after word 1 -> outputs 0 immediately; post-reset read of same address misses and refills all 4 words.

Source files
------------

// File: rtl/inst_cache_2way.sv
// Two-way set-associative, read-only instruction cache with per-set LRU.
// Misses refill a whole line over an sram-like bus; 0xA000_0000-0xBFFF_FFFF bypasses the cache.
module inst_cache_2way #(
  parameter int INDEX_WIDTH  = 7,
  parameter int OFFSET_WIDTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        inv_all,
  input  logic        cpu_inst_req,
  input  logic        cpu_inst_wr,
  input  logic [1:0]  cpu_inst_size,
  input  logic [31:0] cpu_inst_addr,
  input  logic [31:0] cpu_inst_wdata,
  output logic [31:0] cpu_inst_rdata,
  output logic        cpu_inst_addr_ok,
  output logic        cpu_inst_data_ok,
  output logic        cache_inst_req,
  output logic        cache_inst_wr,
  output logic [1:0]  cache_inst_size,
  output logic [31:0] cache_inst_addr,
  output logic [31:0] cache_inst_wdata,
  input  logic [31:0] cache_inst_rdata,
  input  logic        cache_inst_addr_ok,
  input  logic        cache_inst_data_ok
);
  localparam int SETS      = 1 << INDEX_WIDTH;
  localparam int WORDS     = 1 << (OFFSET_WIDTH - 2);
  localparam int TAG_WIDTH = 32 - INDEX_WIDTH - OFFSET_WIDTH;
  localparam int CW        = (OFFSET_WIDTH > 2) ? OFFSET_WIDTH - 2 : 1;

  typedef enum logic [1:0] {IDLE, REFILL, UNCACHED, RESP} state_t;
  state_t state, state_nx;

  logic [SETS-1:0]      valid0, valid1, lru;
  logic [TAG_WIDTH-1:0] tag0 [SETS];
  logic [TAG_WIDTH-1:0] tag1 [SETS];
  logic [31:0]          data0 [SETS][WORDS];
  logic [31:0]          data1 [SETS][WORDS];
  logic [31:0]          line_buf [WORDS];

  logic [31:0] cap_addr;
  logic        cap_victim;
  logic [CW-1:0] counter;
  logic        addr_rcv;
  logic [31:0] resp_word;

  logic [TAG_WIDTH-1:0]   req_tag, cap_tag;
  logic [INDEX_WIDTH-1:0] req_index, cap_index;
  logic [CW-1:0]          req_word, cap_word;
  logic req_uncached, hit0, hit1, lookup, hit, miss, victim_sel;
  logic bus_data_ok, fill_last;

  assign req_tag      = cpu_inst_addr[31 -: TAG_WIDTH];
  assign req_index    = cpu_inst_addr[OFFSET_WIDTH +: INDEX_WIDTH];
  assign req_word     = (WORDS == 1) ? '0 : cpu_inst_addr[2 +: CW];
  assign cap_tag      = cap_addr[31 -: TAG_WIDTH];
  assign cap_index    = cap_addr[OFFSET_WIDTH +: INDEX_WIDTH];
  assign cap_word     = (WORDS == 1) ? '0 : cap_addr[2 +: CW];
  assign req_uncached = (cpu_inst_addr[31:29] == 3'b101);

  assign hit0   = valid0[req_index] && (tag0[req_index] == req_tag);
  assign hit1   = valid1[req_index] && (tag1[req_index] == req_tag);
  // inv_all blocks the whole lookup, so a request seen with it is retried next cycle.
  assign lookup = (state == IDLE) && cpu_inst_req && !inv_all;
  assign hit    = lookup && !req_uncached && (hit0 || hit1);
  assign miss   = lookup && !hit;
  assign victim_sel = !valid0[req_index] ? 1'b0 :
                      !valid1[req_index] ? 1'b1 : lru[req_index];

  // A data_ok without an accepted address (e.g. left over from before reset) is dropped.
  assign bus_data_ok = addr_rcv && cache_inst_data_ok;
  assign fill_last   = (state == REFILL) && bus_data_ok && (counter == CW'(WORDS - 1));

  assign cache_inst_wr    = 1'b0;
  assign cache_inst_size  = 2'b10;
  assign cache_inst_wdata = 32'h0;

  logic unused_inputs;
  assign unused_inputs = ^{cpu_inst_wr, cpu_inst_size, cpu_inst_wdata, cap_addr[1:0]};

  always_comb begin
    state_nx         = state;
    cpu_inst_addr_ok = 1'b0;
    cpu_inst_data_ok = 1'b0;
    cpu_inst_rdata   = 32'h0;
    cache_inst_req   = 1'b0;
    cache_inst_addr  = 32'h0;
    case (state)
      IDLE: begin
        if (hit) begin
          cpu_inst_addr_ok = 1'b1;
          cpu_inst_data_ok = 1'b1;
          cpu_inst_rdata   = hit0 ? data0[req_index][req_word] : data1[req_index][req_word];
        end else if (miss) begin
          state_nx = req_uncached ? UNCACHED : REFILL;
        end
      end
      REFILL: begin
        cache_inst_req  = !addr_rcv;
        cache_inst_addr = {cap_addr[31:OFFSET_WIDTH], {OFFSET_WIDTH{1'b0}}} | (32'(counter) << 2);
        if (fill_last) state_nx = RESP;
      end
      UNCACHED: begin
        cache_inst_req  = !addr_rcv;
        cache_inst_addr = {cap_addr[31:2], 2'b00};
        if (bus_data_ok) state_nx = RESP;
      end
      RESP: begin
        cpu_inst_addr_ok = 1'b1;
        cpu_inst_data_ok = 1'b1;
        cpu_inst_rdata   = resp_word;
        state_nx         = IDLE;
      end
      default: state_nx = IDLE;
    endcase
    if (rst) begin
      cache_inst_req   = 1'b0;
      cpu_inst_addr_ok = 1'b0;
      cpu_inst_data_ok = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      counter    <= '0;
      addr_rcv   <= 1'b0;
      valid0     <= '0;
      valid1     <= '0;
      lru        <= '0;
      cap_addr   <= 32'h0;
      cap_victim <= 1'b0;
      resp_word  <= 32'h0;
    end else begin
      state <= state_nx;
      if (cache_inst_req && cache_inst_addr_ok) addr_rcv <= 1'b1;
      else if (bus_data_ok)                      addr_rcv <= 1'b0;
      if ((state == IDLE) && inv_all) begin
        valid0 <= '0;
        valid1 <= '0;
        lru    <= '0;
      end
      // LRU names the way to replace next, i.e. the one not just used.
      if (hit) lru[req_index] <= hit0;
      if (miss) begin
        cap_addr   <= cpu_inst_addr;
        cap_victim <= victim_sel;
        counter    <= '0;
      end
      if ((state == REFILL) && bus_data_ok) begin
        counter <= counter + CW'(1);
        if (counter == cap_word) resp_word <= cache_inst_rdata;
        if (fill_last) begin
          if (cap_victim) valid1[cap_index] <= 1'b1;
          else            valid0[cap_index] <= 1'b1;
          lru[cap_index] <= !cap_victim;
        end
      end
      if ((state == UNCACHED) && bus_data_ok) resp_word <= cache_inst_rdata;
    end
  end

  // Tag and data storage carry no reset; valid bits alone qualify them.
  always_ff @(posedge clk) begin
    if ((state == REFILL) && bus_data_ok) line_buf[counter] <= cache_inst_rdata;
    if (fill_last) begin
      if (cap_victim) tag1[cap_index] <= cap_tag;
      else            tag0[cap_index] <= cap_tag;
      for (int w = 0; w < WORDS; w++) begin
        if (cap_victim) data1[cap_index][w] <= (w == WORDS - 1) ? cache_inst_rdata : line_buf[w];
        else            data0[cap_index][w] <= (w == WORDS - 1) ? cache_inst_rdata : line_buf[w];
      end
    end
  end
endmodule

// File: tb/tb_inst_cache_2way.sv
// Bench for inst_cache_2way: directed read table plus hand-written inv_all, slow-bus and reset sequences.
// A small sram-like bus model answers refills; issued bus addresses are checked against an expected queue.
module tb_inst_cache_2way;
  logic        clk = 1'b0;
  logic        rst;
  logic        inv_all;
  logic        cpu_inst_req, cpu_inst_wr;
  logic [1:0]  cpu_inst_size;
  logic [31:0] cpu_inst_addr, cpu_inst_wdata, cpu_inst_rdata;
  logic        cpu_inst_addr_ok, cpu_inst_data_ok;
  logic        cache_inst_req, cache_inst_wr;
  logic [1:0]  cache_inst_size;
  logic [31:0] cache_inst_addr, cache_inst_wdata, cache_inst_rdata;
  logic        cache_inst_addr_ok, cache_inst_data_ok;

  inst_cache_2way dut (
    .clk(clk), .rst(rst), .inv_all(inv_all),
    .cpu_inst_req(cpu_inst_req), .cpu_inst_wr(cpu_inst_wr), .cpu_inst_size(cpu_inst_size),
    .cpu_inst_addr(cpu_inst_addr), .cpu_inst_wdata(cpu_inst_wdata), .cpu_inst_rdata(cpu_inst_rdata),
    .cpu_inst_addr_ok(cpu_inst_addr_ok), .cpu_inst_data_ok(cpu_inst_data_ok),
    .cache_inst_req(cache_inst_req), .cache_inst_wr(cache_inst_wr), .cache_inst_size(cache_inst_size),
    .cache_inst_addr(cache_inst_addr), .cache_inst_wdata(cache_inst_wdata),
    .cache_inst_rdata(cache_inst_rdata), .cache_inst_addr_ok(cache_inst_addr_ok),
    .cache_inst_data_ok(cache_inst_data_ok)
  );

  // clock / reset
  always #5 clk = ~clk;

  localparam logic [31:0] K = 32'h5A5A_5A5A;
  localparam int HIT = 0, FILL = 1, UNC = 2;

  int errors = 0;
  int checks = 0;
  logic [31:0] exp_q[$];
  logic [31:0] bus_log[$];

  function automatic logic [31:0] bus_data(input logic [31:0] a);
    if (a[31:4] == 28'h0000100) return 32'h11 * (32'(a[3:2]) + 32'd1);
    return a ^ K;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // sram-like bus model: addr_ok after addr_delay cycles, data_ok data_delay cycles later
  int addr_delay = 0, data_delay = 0;
  int overlap_err = 0, drop_err = 0, dcount = 0;
  logic pend = 1'b0, stale = 1'b0;
  logic [31:0] paddr;
  int acnt = 0, dcnt = 0;

  initial begin
    cache_inst_addr_ok = 1'b0;
    cache_inst_data_ok = 1'b0;
    cache_inst_rdata   = 32'h0;
    forever begin
      @(negedge clk);
      cache_inst_addr_ok = 1'b0;
      cache_inst_data_ok = 1'b0;
      if (pend) begin
        if (cache_inst_req && !stale) overlap_err++;
        if (dcnt >= data_delay) begin
          cache_inst_data_ok = 1'b1;
          cache_inst_rdata   = bus_data(paddr);
          pend = 1'b0;
          dcount++;
        end else dcnt++;
      end else if (cache_inst_req) begin
        if (acnt >= addr_delay) begin
          cache_inst_addr_ok = 1'b1;
          paddr = cache_inst_addr;
          bus_log.push_back(paddr);
          pend = 1'b1; stale = 1'b0; dcnt = 0; acnt = 0;
        end else acnt++;
      end else begin
        if (acnt > 0 && !rst) drop_err++;
        acnt = 0;
      end
      if (rst && pend) stale = 1'b1;
    end
  end

  // driver tasks
  task automatic cpu_wait(output logic [31:0] data, output int lat, output logic dok);
    lat = 0; data = 32'h0; dok = 1'b0;
    forever begin
      @(negedge clk);
      if (cpu_inst_addr_ok) begin
        data = cpu_inst_rdata;
        dok  = cpu_inst_data_ok;
        break;
      end
      lat++;
      if (lat > 2000) begin
        checks++; errors++;
        $display("FAIL timeout: no addr_ok within 2000 cycles for %h", cpu_inst_addr);
        break;
      end
    end
    @(posedge clk); #1;
    cpu_inst_req = 1'b0;
  endtask

  task automatic prep_exp(input logic [31:0] addr, input int kind);
    bus_log.delete();
    exp_q.delete();
    if (kind == FILL) for (int i = 0; i < 4; i++) exp_q.push_back({addr[31:4], 4'h0} + 32'(4 * i));
    if (kind == UNC) exp_q.push_back({addr[31:2], 2'b00});
  endtask

  task automatic finish_read(input string name, input int kind, input logic [31:0] exp_data);
    logic [31:0] data;
    int lat;
    logic dok;
    cpu_wait(data, lat, dok);
    check({name, " rdata"}, data, exp_data);
    check({name, " same-cycle hit"}, 32'(lat == 0), 32'(kind == HIT));
    check({name, " data_ok"}, 32'(dok), 32'd1);
    check({name, " bus count"}, bus_log.size(), exp_q.size());
    while (exp_q.size() > 0 && bus_log.size() > 0)
      check({name, " bus addr"}, bus_log.pop_front(), exp_q.pop_front());
  endtask

  task automatic check_read(input string name, input logic [31:0] addr, input int kind,
                            input logic [31:0] exp_data);
    prep_exp(addr, kind);
    @(posedge clk); #1;
    cpu_inst_req  = 1'b1;
    cpu_inst_addr = addr;
    finish_read(name, kind, exp_data);
  endtask

  typedef struct {
    logic [31:0] addr;
    int          kind;
    logic [31:0] data;
  } vec_t;
  vec_t vecs[16];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int target, guard;
    vecs[0]  = '{32'h0000_1004, FILL, 32'h22};
    vecs[1]  = '{32'h0000_100C, HIT,  32'h44};
    vecs[2]  = '{32'h0000_2000, FILL, 32'h0000_2000 ^ K};
    vecs[3]  = '{32'h0000_1008, HIT,  32'h33};
    vecs[4]  = '{32'h0000_3000, FILL, 32'h0000_3000 ^ K};  // C evicts B (way1)
    vecs[5]  = '{32'h0000_3004, HIT,  32'h0000_3004 ^ K};
    vecs[6]  = '{32'h0000_2000, FILL, 32'h0000_2000 ^ K};  // B misses, evicts A (way0)
    vecs[7]  = '{32'h0000_3008, HIT,  32'h0000_3008 ^ K};
    vecs[8]  = '{32'h0000_1000, FILL, 32'h11};             // A gone, evicts B
    vecs[9]  = '{32'hBFC0_0000, UNC,  32'hBFC0_0000 ^ K};
    vecs[10] = '{32'hBFC0_0000, UNC,  32'hBFC0_0000 ^ K};
    vecs[11] = '{32'hBFC0_0006, UNC,  32'hBFC0_0004 ^ K};
    vecs[12] = '{32'h0000_100C, HIT,  32'h44};
    vecs[13] = '{32'h0000_3000, HIT,  32'h0000_3000 ^ K};
    vecs[14] = '{32'h8000_1010, FILL, 32'h8000_1010 ^ K};
    vecs[15] = '{32'h8000_101C, HIT,  32'h8000_101C ^ K};

    rst = 1'b1; inv_all = 1'b0;
    cpu_inst_req = 1'b0; cpu_inst_wr = 1'b0; cpu_inst_size = 2'b10;
    cpu_inst_addr = 32'h0; cpu_inst_wdata = 32'h0;
    #1;
    check("reset cache_inst_req", 32'(cache_inst_req), 32'd0);
    check("reset addr_ok", 32'(cpu_inst_addr_ok), 32'd0);
    check("reset data_ok", 32'(cpu_inst_data_ok), 32'd0);
    repeat (2) @(negedge clk);
    check("const wr", 32'(cache_inst_wr), 32'd0);
    check("const size", 32'(cache_inst_size), 32'd2);
    check("const wdata", cache_inst_wdata, 32'h0);
    rst = 1'b0;
    @(negedge clk);
    check("idle no-req addr_ok", 32'(cpu_inst_addr_ok), 32'd0);
    check("idle no-req data_ok", 32'(cpu_inst_data_ok), 32'd0);
    check("idle no-req bus req", 32'(cache_inst_req), 32'd0);

    for (int i = 0; i < 16; i++)
      check_read($sformatf("vec%0d", i), vecs[i].addr, vecs[i].kind, vecs[i].data);

    // inv_all while idle, then the 0x1000 line must refill
    @(posedge clk); #1; inv_all = 1'b1;
    @(posedge clk); #1; inv_all = 1'b0;
    check_read("inv idle", 32'h0000_1000, FILL, 32'h11);
    check_read("inv refilled hit", 32'h0000_1008, HIT, 32'h33);

    // inv_all coinciding with a would-be hit suppresses it
    prep_exp(32'h0000_1004, FILL);
    @(posedge clk); #1;
    cpu_inst_req = 1'b1; cpu_inst_addr = 32'h0000_1004; inv_all = 1'b1;
    @(negedge clk);
    check("inv suppresses hit", 32'(cpu_inst_addr_ok), 32'd0);
    @(posedge clk); #1; inv_all = 1'b0;
    finish_read("inv with req", FILL, 32'h22);

    // slow bus
    addr_delay = 3; data_delay = 5;
    check_read("slow fill", 32'h0000_5044, FILL, 32'h0000_5044 ^ K);
    check_read("slow uncached", 32'hA000_0008, UNC, 32'hA000_0008 ^ K);
    addr_delay = 0; data_delay = 0;
    check_read("slow line hit", 32'h0000_504C, HIT, 32'h0000_504C ^ K);

    // reset in the middle of a refill, after word 1 has been taken
    bus_log.delete();
    target = dcount + 2;
    guard = 0;
    @(posedge clk); #1;
    cpu_inst_req = 1'b1; cpu_inst_addr = 32'h0000_6024;
    while (dcount < target && guard < 200) begin
      @(negedge clk); #2;
      guard++;
    end
    check("mid-refill words seen", 32'(dcount >= target), 32'd1);
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    check("rst mid-refill bus req", 32'(cache_inst_req), 32'd0);
    check("rst mid-refill addr_ok", 32'(cpu_inst_addr_ok), 32'd0);
    check("rst mid-refill data_ok", 32'(cpu_inst_data_ok), 32'd0);
    cpu_inst_req = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (10) @(negedge clk);
    check_read("post-rst refill", 32'h0000_6024, FILL, 32'h0000_6024 ^ K);
    check_read("post-rst hit", 32'h0000_6020, HIT, 32'h0000_6020 ^ K);
    check_read("post-rst old line", 32'h0000_1004, FILL, 32'h22);

    check("bus overlapping requests", overlap_err, 32'd0);
    check("bus req dropped before addr_ok", drop_err, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
